// File: rtl/pmu_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pmu_cfg_arbiter
// Purpose  : Round-robin arbiter that serialises single-register writes from
//            several requesters into a shadow copy of the PMU register array
//            and strobes the PMU write enable once per accepted write.
// Revision : 1.0  initial release
// ============================================================================
module pmu_cfg_arbiter #(
  parameter int REG_WIDTH     = 32,
  parameter int N_REGS        = 43,
  parameter int ADDR_W        = 6,
  parameter int N_REQ         = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]       req_addr_i,
  input  logic [N_REQ*REG_WIDTH-1:0]    req_data_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic [N_REQ-1:0]              req_err_o,
  output logic [N_REGS*REG_WIDTH-1:0]   pmu_regs_o,
  output logic                          pmu_we_o,
  output logic                          busy_o,
  output logic [$clog2(N_REQ)-1:0]      grant_idx_o
);

  localparam int               IDX_W       = $clog2(N_REQ);
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] PTR_RESET   = IDX_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t                         state, state_next;
  logic [IDX_W-1:0]               rr_ptr;
  logic [IDX_W-1:0]               grant_idx;
  logic [3:0]                     settle_cnt;
  logic [N_REGS*REG_WIDTH-1:0]    shadow;

  logic                           found_hi, found_lo, found;
  logic [IDX_W-1:0]               idx_hi, idx_lo, winner;
  logic [ADDR_W-1:0]              win_addr;
  logic [REG_WIDTH-1:0]           win_data;
  logic                           addr_ok;
  logic                           accept;
  logic                           accept_ok;

  // Round-robin search: the lowest valid index above the pointer wins,
  // otherwise wrap around to the lowest valid index at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        if (IDX_W'(k) > rr_ptr) begin
          found_hi = 1'b1;
          idx_hi   = IDX_W'(k);
        end else begin
          found_lo = 1'b1;
          idx_lo   = IDX_W'(k);
        end
      end
    end
    found  = found_hi | found_lo;
    winner = found_hi ? idx_hi : idx_lo;
  end

  // Select the winning requester's address and data, and qualify the address.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (winner == IDX_W'(k)) begin
        win_addr = req_addr_i[k*ADDR_W +: ADDR_W];
        win_data = req_data_i[k*REG_WIDTH +: REG_WIDTH];
      end
    end
    addr_ok   = (32'(win_addr) < 32'(N_REGS));
    accept    = (state == IDLE) && found;
    accept_ok = accept && addr_ok;
  end

  // One-hot ready/err pulses; err always coincides with ready on a bad index.
  always_comb begin
    req_ready_o = '0;
    req_err_o   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_ready_o[k] = accept && (winner == IDX_W'(k));
      req_err_o[k]   = accept && (winner == IDX_W'(k)) && !addr_ok;
    end
  end

  // Next-state logic: a good accept strobes, then optionally settles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_ok) state_next = STROBE;
      STROBE:  state_next = (SETTLE_CYCLES > 0) ? SETTLE : IDLE;
      SETTLE:  if (settle_cnt <= 4'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_next;
  end

  // Pointer and reported grant follow every accepted handshake, good or bad.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr    <= PTR_RESET;
      grant_idx <= '0;
    end else if (accept) begin
      rr_ptr    <= winner;
      grant_idx <= winner;
    end
  end

  // Settle down-counter, loaded while strobing and counted down while settling.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                settle_cnt <= '0;
    else if (state == STROBE)   settle_cnt <= SETTLE_LOAD;
    else if (state == SETTLE)   settle_cnt <= settle_cnt - 4'd1;
  end

  // Shadow array: only the addressed register changes on a good accept.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shadow <= '0;
    end else begin
      for (int r = 0; r < N_REGS; r++) begin
        if (accept_ok && (win_addr == ADDR_W'(r)))
          shadow[r*REG_WIDTH +: REG_WIDTH] <= win_data;
      end
    end
  end

  assign pmu_regs_o  = shadow;
  assign pmu_we_o    = (state == STROBE);
  assign busy_o      = (state != IDLE);
  assign grant_idx_o = grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_pmu_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmu_cfg_arbiter
// Purpose  : Self-checking bench for pmu_cfg_arbiter (SETTLE_CYCLES=1 and 0).
// Revision : 1.0  initial release
// ============================================================================
module tb_pmu_cfg_arbiter;

  localparam int RW = 32;
  localparam int NR = 43;
  localparam int AW = 6;
  localparam int NQ = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
  } wr_t;

  typedef struct {
    logic [NQ-1:0] valid;
    logic [AW-1:0] a0, a1, a2;
    logic [NQ-1:0] exp_ready;
    logic [NQ-1:0] exp_err;
    logic [1:0]    exp_gidx;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // DUT with SETTLE_CYCLES=1
  logic [NQ-1:0]    v1, rdy1, err1;
  logic [NQ*AW-1:0] a1;
  logic [NQ*RW-1:0] d1;
  logic [NR*RW-1:0] regs1;
  logic             we1, busy1;
  logic [1:0]       gi1;

  // DUT with SETTLE_CYCLES=0
  logic [NQ-1:0]    v0, rdy0, err0;
  logic [NQ*AW-1:0] a0;
  logic [NQ*RW-1:0] d0;
  logic [NR*RW-1:0] regs0;
  logic             we0, busy0;
  logic [1:0]       gi0;

  pmu_cfg_arbiter #(.REG_WIDTH(RW), .N_REGS(NR), .ADDR_W(AW), .N_REQ(NQ), .SETTLE_CYCLES(1)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(v1), .req_addr_i(a1), .req_data_i(d1),
    .req_ready_o(rdy1), .req_err_o(err1), .pmu_regs_o(regs1), .pmu_we_o(we1),
    .busy_o(busy1), .grant_idx_o(gi1));

  pmu_cfg_arbiter #(.REG_WIDTH(RW), .N_REGS(NR), .ADDR_W(AW), .N_REQ(NQ), .SETTLE_CYCLES(0)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(v0), .req_addr_i(a0), .req_data_i(d0),
    .req_ready_o(rdy0), .req_err_o(err0), .pmu_regs_o(regs0), .pmu_we_o(we0),
    .busy_o(busy0), .grant_idx_o(gi0));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cnt1 = 0;
  int rdy0_cnt1 = 0;
  wr_t q1[$];
  wr_t q0[$];
  int stimes0[$];
  logic [RW-1:0] model1 [NR];
  logic [RW-1:0] model0 [NR];
  logic [RW-1:0] zeros  [NR];
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_array(input string name, input logic [NR*RW-1:0] regs, input logic [RW-1:0] m [NR]);
    int bad;
    bad = -1;
    for (int r = 0; r < NR; r++)
      if (bad < 0 && regs[r*RW +: RW] !== m[r]) bad = r;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s reg %0d actual %h expected %h", name, bad, regs[bad*RW +: RW], m[bad]);
    end
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard for dut1: every strobe must match the next expected write.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (!rstn) begin
      q1.delete();
      for (int r = 0; r < NR; r++) model1[r] = '0;
    end else begin
      if (rdy1[0]) rdy0_cnt1++;
      if (we1) begin
        we_cnt1++;
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL strobe1_spurious actual we=1 expected no strobe (t=%0t)", $time);
        end else begin
          e = q1.pop_front();
          model1[e.addr] = e.data;
          chk("strobe1_reg", regs1[e.addr*RW +: RW], e.data);
          cmp_array("strobe1_array", regs1, model1);
        end
      end
    end
  end

  // Scoreboard for dut0.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (!rstn) begin
      q0.delete();
      for (int r = 0; r < NR; r++) model0[r] = '0;
    end else if (we0) begin
      stimes0.push_back(cyc);
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL strobe0_spurious actual we=1 expected no strobe (t=%0t)", $time);
      end else begin
        e = q0.pop_front();
        model0[e.addr] = e.data;
        chk("strobe0_reg", regs0[e.addr*RW +: RW], e.data);
        cmp_array("strobe0_array", regs0, model0);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    v1 = '0;
    v0 = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic wait_idle1();
    int n;
    n = 0;
    @(negedge clk);
    while (busy1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle1_timeout", {31'd0, busy1}, 32'd0);
  endtask

  task automatic push1(input logic [AW-1:0] ad, input logic [RW-1:0] dt);
    wr_t e;
    e.addr = ad;
    e.data = dt;
    q1.push_back(e);
  endtask

  task automatic push0(input logic [AW-1:0] ad, input logic [RW-1:0] dt);
    wr_t e;
    e.addr = ad;
    e.data = dt;
    q0.push_back(e);
  endtask

  initial begin
    int base_we, base_r0, n, last, w;
    logic [RW-1:0] dat [NQ];

    for (int r = 0; r < NR; r++) begin
      model1[r] = '0; model0[r] = '0; zeros[r] = '0;
    end
    rstn = 1'b1; v1 = '0; a1 = '0; d1 = '0; v0 = '0; a0 = '0; d0 = '0;
    #2;

    // Arbitration vectors, starting from a fresh reset (pointer = 2)
    tbl[0] = '{3'b111, 6'd1,  6'd2, 6'd3,  3'b001, 3'b000, 2'd0};
    tbl[1] = '{3'b111, 6'd1,  6'd2, 6'd3,  3'b010, 3'b000, 2'd1};
    tbl[2] = '{3'b101, 6'd4,  6'd5, 6'd6,  3'b100, 3'b000, 2'd2};
    tbl[3] = '{3'b011, 6'd60, 6'd7, 6'd8,  3'b001, 3'b001, 2'd0};
    tbl[4] = '{3'b011, 6'd9,  6'd10,6'd11, 3'b010, 3'b000, 2'd1};
    tbl[5] = '{3'b001, 6'd12, 6'd13,6'd14, 3'b001, 3'b000, 2'd0};
    tbl[6] = '{3'b100, 6'd15, 6'd16,6'd42, 3'b100, 3'b000, 2'd2};
    tbl[7] = '{3'b100, 6'd17, 6'd18,6'd43, 3'b100, 3'b100, 2'd2};
    tbl[8] = '{3'b110, 6'd19, 6'd20,6'd21, 3'b010, 3'b000, 2'd1};

    // ---- Test 1: reset state, then single write from requester 1
    do_reset();
    @(negedge clk);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_we", {31'd0, we1}, 32'd0);
    chk("rst_gidx", {30'd0, gi1}, 32'd0);
    chk("rst_ready", {29'd0, rdy1}, 32'd0);
    chk("rst_err", {29'd0, err1}, 32'd0);
    cmp_array("rst_array", regs1, zeros);
    step();
    v1 = 3'b010; a1[AW +: AW] = 6'd0; d1[RW +: RW] = 32'h00000012;
    push1(6'd0, 32'h00000012);
    @(negedge clk);
    chk("t1_ready", {29'd0, rdy1}, 32'd2);
    chk("t1_err", {29'd0, err1}, 32'd0);
    chk("t1_busy_acc", {31'd0, busy1}, 32'd0);
    step(); v1 = '0;
    @(negedge clk);
    chk("t1_we", {31'd0, we1}, 32'd1);
    chk("t1_busy_strobe", {31'd0, busy1}, 32'd1);
    chk("t1_gidx", {30'd0, gi1}, 32'd1);
    step();
    @(negedge clk);
    chk("t1_we_settle", {31'd0, we1}, 32'd0);
    chk("t1_busy_settle", {31'd0, busy1}, 32'd1);
    step();
    @(negedge clk);
    chk("t1_busy_done", {31'd0, busy1}, 32'd0);

    // ---- Test 2: three simultaneous requesters, strict round robin
    do_reset();
    base_we = we_cnt1;
    v1 = 3'b111;
    a1 = {6'd32, 6'd31, 6'd30};
    d1 = {32'hbbbbbbbb, 32'haaaaaaaa, 32'hffffffff};
    push1(6'd30, 32'hffffffff); push1(6'd31, 32'haaaaaaaa); push1(6'd32, 32'hbbbbbbbb);
    last = 0;
    for (int k = 0; k < NQ; k++) begin
      n = 0;
      @(negedge clk);
      while (rdy1 == 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("t2_ready_%0d", k), {29'd0, rdy1}, 32'd1 << k);
      if (k > 0) chk($sformatf("t2_spacing_%0d", k), cyc - last, 32'd3);
      last = cyc;
      step();
      v1[k] = 1'b0;
    end
    wait_idle1();
    step();
    chk("t2_strobes", we_cnt1 - base_we, 32'd3);
    chk("t2_reg30", regs1[30*RW +: RW], 32'hffffffff);
    chk("t2_reg31", regs1[31*RW +: RW], 32'haaaaaaaa);
    chk("t2_reg32", regs1[32*RW +: RW], 32'hbbbbbbbb);

    // ---- Test 3: invalid address, then immediate good write
    base_we = we_cnt1;
    v1 = 3'b100; a1[2*AW +: AW] = 6'd50; d1[2*RW +: RW] = 32'hdeadbeef;
    @(negedge clk);
    chk("t3_ready_bad", {29'd0, rdy1}, 32'd4);
    chk("t3_err_bad", {29'd0, err1}, 32'd4);
    step();
    v1 = 3'b001; a1[0 +: AW] = 6'd0; d1[0 +: RW] = 32'h00000055;
    push1(6'd0, 32'h00000055);
    @(negedge clk);
    chk("t3_ready_next", {29'd0, rdy1}, 32'd1);
    chk("t3_err_next", {29'd0, err1}, 32'd0);
    chk("t3_gidx_err", {30'd0, gi1}, 32'd2);
    cmp_array("t3_array_unchanged", regs1, model1);
    step(); v1 = '0;
    @(negedge clk);
    chk("t3_we", {31'd0, we1}, 32'd1);
    wait_idle1();
    chk("t3_strobes", we_cnt1 - base_we, 32'd1);

    // ---- Table-driven arbitration vectors
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) wait_idle1();
      step();
      for (int k = 0; k < NQ; k++) dat[k] = 32'hC0DE0000 + 32'(i * 16 + k);
      v1 = tbl[i].valid;
      a1 = {tbl[i].a2, tbl[i].a1, tbl[i].a0};
      d1 = {dat[2], dat[1], dat[0]};
      w = 0;
      for (int k = 0; k < NQ; k++) if (tbl[i].exp_ready[k]) w = k;
      if (tbl[i].exp_err == 0) push1(a1[w*AW +: AW], dat[w]);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), {29'd0, rdy1}, {29'd0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_err", i), {29'd0, err1}, {29'd0, tbl[i].exp_err});
      step(); v1 = '0;
      @(negedge clk);
      chk($sformatf("tbl%0d_gidx", i), {30'd0, gi1}, {30'd0, tbl[i].exp_gidx});
    end
    wait_idle1();

    // ---- Test 6: requester 0 withdraws while requester 1 is served
    step();
    base_we = we_cnt1;
    base_r0 = rdy0_cnt1;
    v1 = 3'b010; a1[AW +: AW] = 6'd5; d1[RW +: RW] = 32'h00000066;
    push1(6'd5, 32'h00000066);
    @(negedge clk);
    chk("t6_ready1", {29'd0, rdy1}, 32'd2);
    step();
    v1 = 3'b001; a1[0 +: AW] = 6'd7; d1[0 +: RW] = 32'h00000077;
    @(negedge clk);
    chk("t6_ready_strobe", {29'd0, rdy1}, 32'd0);
    chk("t6_we", {31'd0, we1}, 32'd1);
    step(); v1 = '0;
    @(negedge clk);
    chk("t6_ready_settle", {29'd0, rdy1}, 32'd0);
    repeat (5) step();
    chk("t6_req0_never", rdy0_cnt1 - base_r0, 32'd0);
    chk("t6_strobes", we_cnt1 - base_we, 32'd1);
    chk("t6_reg7", regs1[7*RW +: RW], 32'd0);

    // ---- Test 5: reset during the STROBE cycle
    v1 = 3'b001; a1[0 +: AW] = 6'd0; d1[0 +: RW] = 32'h40000001;
    @(negedge clk);
    chk("t5_ready", {29'd0, rdy1}, 32'd1);
    step(); v1 = '0;
    #1;
    chk("t5_we_before", {31'd0, we1}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("t5_we_async", {31'd0, we1}, 32'd0);
    cmp_array("t5_array_async", regs1, zeros);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("t5_busy", {31'd0, busy1}, 32'd0);
    chk("t5_gidx", {30'd0, gi1}, 32'd0);
    cmp_array("t5_array_after", regs1, zeros);
    step();
    v1 = 3'b011; a1 = {6'd0, 6'd2, 6'd1}; d1 = {32'd0, 32'h00000022, 32'h00000011};
    push1(6'd1, 32'h00000011);
    @(negedge clk);
    chk("t5_priority", {29'd0, rdy1}, 32'd1);
    step(); v1 = '0;
    wait_idle1();

    // ---- Test 4: SETTLE_CYCLES=0 back-to-back writes
    step();
    stimes0.delete();
    v0 = 3'b001; a0[0 +: AW] = 6'd38; d0[0 +: RW] = 32'h01020304;
    push0(6'd38, 32'h01020304); push0(6'd39, 32'h05060708);
    @(negedge clk);
    chk("t4_ready_a", {29'd0, rdy0}, 32'd1);
    step();
    a0[0 +: AW] = 6'd39; d0[0 +: RW] = 32'h05060708;
    @(negedge clk);
    chk("t4_ready_strobe", {29'd0, rdy0}, 32'd0);
    chk("t4_we_a", {31'd0, we0}, 32'd1);
    step();
    @(negedge clk);
    chk("t4_ready_b", {29'd0, rdy0}, 32'd1);
    step(); v0 = '0;
    repeat (3) step();
    chk("t4_strobes", stimes0.size(), 32'd2);
    if (stimes0.size() == 2) chk("t4_spacing", stimes0[1] - stimes0[0], 32'd2);
    chk("t4_reg38", regs0[38*RW +: RW], 32'h01020304);
    chk("t4_reg39", regs0[39*RW +: RW], 32'h05060708);
    chk("t4_busy", {31'd0, busy0}, 32'd0);

    // ---- Final: no expected strobes left outstanding
    chk("q1_drained", q1.size(), 32'd0);
    chk("q0_drained", q0.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
